// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_stall_controller_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } md_state_e;

  // Enable/flush/bubble bundle driven into the PC and pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
  } stall_ctrl_t;

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt,
                                     input logic                  uses_rs,
                                     input logic                  uses_rt);
    return (r != REG_ZERO) && ((uses_rs && (r == rs)) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_muldiv_sequencer.sv
// Start/done handshake and timeout watchdog for the multi-cycle mul/div unit in EX.
module muldiv_sequencer
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ex_muldiv,
  input  logic i_md_done,
  output logic o_md_start,
  output logic o_md_error,
  output logic o_md_hold
);

  localparam int unsigned TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MD_TIMEOUT - 1);

  md_state_e     r_state;
  md_state_e     w_state_d;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_d;
  logic          r_err;
  logic          w_err_d;
  logic          w_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    w_start   = 1'b0;
    o_md_hold = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_ex_muldiv) begin
          w_start   = 1'b1;
          o_md_hold = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        o_md_hold = 1'b1;
        w_cnt_d   = r_cnt + 1'b1;
        // A done pulse on the timeout cycle still counts as a clean finish.
        if (i_md_done) begin
          w_state_d = StRelease;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_err_d   = 1'b1;
          w_state_d = StRelease;
        end
      end
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  assign o_md_start = w_start && !i_rst;
  assign o_md_error = r_err;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for a 5-stage MIPS pipeline with branches resolved in Decode.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter bit          DELAY_SLOT = 1'b0,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_branch,
  input  logic                  i_id_branch_taken,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_muldiv,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_mem_read,
  input  logic                  i_md_done,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_write,
  output logic                  o_id_ex_bubble,
  output logic                  o_ex_mem_bubble,
  output logic                  o_md_start,
  output logic                  o_md_error,
  output logic [CNT_W-1:0]      o_stall_count,
  output logic [CNT_W-1:0]      o_flush_count
);

  logic        w_ex_match;
  logic        w_mem_match;
  logic        w_load_use;
  logic        w_br_ex;
  logic        w_br_mem;
  logic        w_dstall;
  logic        w_md_hold;
  logic        w_br_flush;
  stall_ctrl_t w_ctrl;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  muldiv_sequencer #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_muldiv_sequencer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ex_muldiv (i_ex_muldiv),
    .i_md_done   (i_md_done),
    .o_md_start  (o_md_start),
    .o_md_error  (o_md_error),
    .o_md_hold   (w_md_hold)
  );

  assign w_ex_match  = reg_match(i_ex_rd, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt);
  assign w_mem_match = reg_match(i_mem_rd, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt);

  // ALU results reach the ID comparator one cycle late; loads two cycles late.
  assign w_load_use = i_ex_mem_read && w_ex_match;
  assign w_br_ex    = i_id_branch && i_ex_reg_write && !i_ex_mem_read && w_ex_match;
  assign w_br_mem   = i_id_branch && i_mem_mem_read && w_mem_match;
  assign w_dstall   = w_load_use || w_br_ex || w_br_mem;

  always_comb begin
    w_ctrl     = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                   id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_bubble: 1'b0};
    w_br_flush = 1'b0;
    if (i_rst) begin
      w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                 id_ex_write: 1'b0, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b1};
    end else if (w_md_hold) begin
      w_ctrl.pc_write      = 1'b0;
      w_ctrl.if_id_write   = 1'b0;
      w_ctrl.id_ex_write   = 1'b0;
      w_ctrl.ex_mem_bubble = 1'b1;
    end else if (w_dstall) begin
      // Branch outcome is computed from stale operands here, so never flush.
      w_ctrl.pc_write     = 1'b0;
      w_ctrl.if_id_write  = 1'b0;
      w_ctrl.id_ex_bubble = 1'b1;
    end else if (i_id_branch_taken && !DELAY_SLOT) begin
      w_ctrl.if_id_flush = 1'b1;
      w_br_flush         = 1'b1;
    end
  end

  assign o_pc_write      = w_ctrl.pc_write;
  assign o_if_id_write   = w_ctrl.if_id_write;
  assign o_if_id_flush   = w_ctrl.if_id_flush;
  assign o_id_ex_write   = w_ctrl.id_ex_write;
  assign o_id_ex_bubble  = w_ctrl.id_ex_bubble;
  assign o_ex_mem_bubble = w_ctrl.ex_mem_bubble;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_br_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_count = r_stall_cnt;
  assign o_flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: per-cycle expected control vectors are queued
// as stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_pipeline_stall_controller;

  localparam int unsigned CNT_W = 4;

  // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble, md_start, md_error}
  localparam logic [7:0] NORM  = 8'b1110_0000;
  localparam logic [7:0] RSTV  = 8'b0001_1100;
  localparam logic [7:0] DST   = 8'b0010_1000;
  localparam logic [7:0] FLUSH = 8'b1111_0000;
  localparam logic [7:0] MDH   = 8'b0000_0100;
  localparam logic [7:0] MDS   = 8'b0000_0110;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, id_branch, id_taken;
  logic ex_rw, ex_mr, ex_md, mem_mr, md_done;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble;
  logic md_start, md_error;
  logic [CNT_W-1:0] stall_count, flush_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got, e;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .DELAY_SLOT (1'b0),
    .MD_TIMEOUT (8),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rs      (id_uses_rs),
    .i_id_uses_rt      (id_uses_rt),
    .i_id_branch       (id_branch),
    .i_id_branch_taken (id_taken),
    .i_ex_rd           (ex_rd),
    .i_ex_reg_write    (ex_rw),
    .i_ex_mem_read     (ex_mr),
    .i_ex_muldiv       (ex_md),
    .i_mem_rd          (mem_rd),
    .i_mem_mem_read    (mem_mr),
    .i_md_done         (md_done),
    .o_pc_write        (pc_write),
    .o_if_id_write     (if_id_write),
    .o_if_id_flush     (if_id_flush),
    .o_id_ex_write     (id_ex_write),
    .o_id_ex_bubble    (id_ex_bubble),
    .o_ex_mem_bubble   (ex_mem_bubble),
    .o_md_start        (md_start),
    .o_md_error        (md_error),
    .o_stall_count     (stall_count),
    .o_flush_count     (flush_count)
  );

  function automatic logic [7:0] outs();
    return {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble,
            md_start, md_error};
  endfunction

  task automatic clear_in();
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_branch = 1'b0; id_taken = 1'b0;
    ex_rw = 1'b0; ex_mr = 1'b0; ex_md = 1'b0; mem_mr = 1'b0; md_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_in();
      case (i)
        0: begin
          rst = 1'b1; ex_md = 1'b1; ex_mr = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
          exp_q.push_back(RSTV);
        end
        1: begin md_done = 1'b1; exp_q.push_back(NORM); end
        default: begin id_taken = 1'b1; exp_q.push_back(FLUSH); end
      endcase
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd0 || flush_count !== 4'd1) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d expected stall=0 flush=1",
               stall_count, flush_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_in();
      case (i)
        0: begin
          ex_mr = 1'b1; ex_rw = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
          exp_q.push_back(DST);
        end
        1: begin id_rs = 5'd8; id_uses_rs = 1'b1; exp_q.push_back(NORM); end
        2: begin ex_mr = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rt = 5'd8; exp_q.push_back(NORM); end
        3: begin
          ex_mr = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; exp_q.push_back(DST);
        end
        default: begin
          ex_mr = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; exp_q.push_back(NORM);
        end
      endcase
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL load_use cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd2 || flush_count !== 4'd0) begin
      errors++;
      $display("FAIL load_use_counters: got stall=%0d flush=%0d expected stall=2 flush=0",
               stall_count, flush_count);
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_in();
      case (i)
        0: begin
          ex_mr = 1'b1; ex_rw = 1'b1; ex_rd = 5'd8;
          id_branch = 1'b1; id_taken = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
          exp_q.push_back(DST);
        end
        1: begin
          mem_mr = 1'b1; mem_rd = 5'd8;
          id_branch = 1'b1; id_taken = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
          exp_q.push_back(DST);
        end
        2: begin
          id_branch = 1'b1; id_taken = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1;
          exp_q.push_back(FLUSH);
        end
        default: exp_q.push_back(NORM);
      endcase
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL load_branch cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd2 || flush_count !== 4'd1) begin
      errors++;
      $display("FAIL load_branch_counters: got stall=%0d flush=%0d expected stall=2 flush=1",
               stall_count, flush_count);
    end
  endtask

  task automatic test_alu_branch();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_in();
      case (i)
        0: begin
          ex_rw = 1'b1; ex_rd = 5'd9; id_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
          exp_q.push_back(DST);
        end
        1: begin id_branch = 1'b1; id_taken = 1'b1; exp_q.push_back(FLUSH); end
        2: begin
          ex_rw = 1'b1; ex_rd = 5'd0; id_branch = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1;
          exp_q.push_back(NORM);
        end
        3: begin ex_rw = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1; exp_q.push_back(NORM); end
        default: begin
          mem_rd = 5'd9; id_branch = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1;
          exp_q.push_back(NORM);
        end
      endcase
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL alu_branch cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd1 || flush_count !== 4'd1) begin
      errors++;
      $display("FAIL alu_branch_counters: got stall=%0d flush=%0d expected stall=1 flush=1",
               stall_count, flush_count);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_in();
      ex_md = (i != 7);
      md_done = (i == 5);
      if (i == 2) begin id_branch = 1'b1; id_taken = 1'b1; end
      if (i == 0) exp_q.push_back(MDS);
      else if (i <= 5) exp_q.push_back(MDH);
      else exp_q.push_back(NORM);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL muldiv cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd6 || flush_count !== 4'd0) begin
      errors++;
      $display("FAIL muldiv_counters: got stall=%0d flush=%0d expected stall=6 flush=0",
               stall_count, flush_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      clear_in();
      ex_md = (i != 6);
      md_done = (i == 1) || (i == 4);
      if (i == 0 || i == 3) exp_q.push_back(MDS);
      else if (i == 1 || i == 4) exp_q.push_back(MDH);
      else exp_q.push_back(NORM);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL back_to_back cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd4) begin
      errors++; $display("FAIL back_to_back_stalls: got %0d expected 4", stall_count);
    end
  endtask

  // Done on the last BUSY cycle, then a real timeout; 18 stalls saturate the 4-bit counter.
  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      clear_in();
      ex_md = (i != 20);
      md_done = (i == 8);
      if (i == 0 || i == 10) exp_q.push_back(MDS);
      else if ((i >= 1 && i <= 8) || (i >= 11 && i <= 18)) exp_q.push_back(MDH);
      else if (i == 9) exp_q.push_back(NORM);
      else exp_q.push_back(NORM | 8'd1);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL timeout cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd15) begin
      errors++; $display("FAIL stall_saturate: got %0d expected 15", stall_count);
    end
  endtask

  // Continues from the sticky error state left by test_timeout.
  task automatic test_reset_mid_busy();
    for (int i = 0; i < 7; i++) begin
      clear_in();
      case (i)
        0: begin id_branch = 1'b1; id_taken = 1'b1; exp_q.push_back(FLUSH | 8'd1); end
        1: begin ex_md = 1'b1; exp_q.push_back(MDS | 8'd1); end
        2, 3: begin ex_md = 1'b1; exp_q.push_back(MDH | 8'd1); end
        4: begin rst = 1'b1; ex_md = 1'b1; exp_q.push_back(RSTV | 8'd1); end
        5: begin md_done = 1'b1; exp_q.push_back(NORM); end
        default: exp_q.push_back(NORM);
      endcase
      @(negedge clk);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset_mid_busy cyc%0d: got %b expected %b", i, got, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_count !== 4'd0 || flush_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_busy_counters: got stall=%0d flush=%0d expected 0 and 0",
               stall_count, flush_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_in();
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_muldiv();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
